snake_move_scheduler: RTL and testbench

Movement scheduler for the snake game. It debounces the four direction keys and latches the difficulty switches. It turns the game status code into a periodic one-cycle `move_tick` and a committed direction `dir`, which together advance the snake body datapath. It sits between the key/switch pins, the game control state machine (`game_status`) and the snake position logic, and applies no-reversal and one-deep direction buffering.

---
 rtl/snake_move_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// snake_move_scheduler
// Debounces the four direction keys, latches the difficulty switches and turns
// the game status code into a periodic one-cycle move_tick plus a committed
// direction dir, with no-reversal filtering and a one-deep pending direction.
//
// Optional feature: define SNAKE_SPEEDUP_EN to shorten the move interval by
// SPEEDUP_STEP cycles per ten points (score tens digit, bcd_data[7:4]),
// floored at PERIOD_MIN. Without it bcd_data is ignored.
//
// game_status | meaning
// ------------+-------------------------------------------------------------
// 01 RESTART  | dir forced right, level loaded from switches, no ticks
// 00 START    | press loads dir directly (no reversal check), no ticks
// 10 PLAY     | interval counter runs, ticks commit the pending direction
// 11 DIE      | everything frozen, only key_any still reports presses

module snake_move_scheduler #(
    parameter int DEB_CYCLES   = 250_000,
    parameter int PERIOD_EASY  = 12_500_000,
    parameter int PERIOD_MID   = 6_250_000,
    parameter int PERIOD_HARD  = 3_125_000,
    parameter int SPEEDUP_STEP = 250_000,
    parameter int PERIOD_MIN   = 1_250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key0_right,
    input  logic        key1_left,
    input  logic        key2_down,
    input  logic        key3_up,
    input  logic        sw0,
    input  logic        sw1,
    input  logic        sw2,
    input  logic [1:0]  game_status,
    input  logic [11:0] bcd_data,
    output logic        move_tick,
    output logic [1:0]  dir,
    output logic [1:0]  level,
    output logic        key_any
);

    typedef enum logic [1:0] {
        ST_START   = 2'b00,
        ST_RESTART = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } status_t;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    status_t          status;
    logic [3:0]       key_raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb_lvl;
    logic [3:0]       deb_prev;
    logic [DEB_W-1:0] deb_cnt [4];
    logic [3:0]       press;
    logic             press_any;
    logic [1:0]       press_dir;
    logic [31:0]      base_period;
    logic [31:0]      period;
    logic [31:0]      tick_cnt;
    logic             pend_vld;
    logic [1:0]       pend_dir;

    assign status  = status_t'(game_status);
    // Bit index doubles as priority: 3 = up wins over everything.
    assign key_raw = {key3_up, key2_down, key1_left, key0_right};

    function automatic logic [1:0] opposite(input logic [1:0] d);
        // up/down and left/right differ only in bit 0
        return {d[1], ~d[0]};
    endfunction

    // Two-flop synchronizer for the asynchronous key pins (idle level is 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: count while the synchronized level disagrees with the accepted
    // level, restart on any agreement, accept after DEB_CYCLES disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl  <= '1;
            deb_prev <= '1;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb_lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press events are debounced falling edges; pick one direction by priority.
    always_comb begin
        press     = deb_prev & ~deb_lvl;
        press_any = |press;
        press_dir = DIR_RIGHT;
        if (press[3]) begin
            press_dir = DIR_UP;
        end else if (press[2]) begin
            press_dir = DIR_DOWN;
        end else if (press[1]) begin
            press_dir = DIR_LEFT;
        end
    end

    // Difficulty latch: follows the switches only while restarting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 2'b01;
        end else if (status == ST_RESTART) begin
            if (!sw2) begin
                level <= 2'b11;
            end else if (!sw1) begin
                level <= 2'b10;
            end else if (!sw0) begin
                level <= 2'b01;
            end
        end
    end

    // Base move interval selected by the latched level.
    always_comb begin
        base_period = 32'(PERIOD_EASY);
        case (level)
            2'b10:   base_period = 32'(PERIOD_MID);
            2'b11:   base_period = 32'(PERIOD_HARD);
            default: base_period = 32'(PERIOD_EASY);
        endcase
    end

`ifdef SNAKE_SPEEDUP_EN
    logic [31:0] reduction;
    logic        unused_bcd;

    assign unused_bcd = ^{bcd_data[11:8], bcd_data[3:0]};

    // Score-dependent interval, clamped so it never drops below the floor.
    always_comb begin
        reduction = 32'(bcd_data[7:4]) * 32'(SPEEDUP_STEP);
        if (reduction + 32'(PERIOD_MIN) > base_period) begin
            period = 32'(PERIOD_MIN);
        end else begin
            period = base_period - reduction;
        end
    end
`else
    localparam int unused_speedup_params = SPEEDUP_STEP + PERIOD_MIN;
    logic unused_bcd;

    assign unused_bcd = ^bcd_data;
    assign period     = base_period;
`endif

    // Interval counter, tick strobe, direction commit and pending buffer.
    // The commit keys off the registered tick, so the datapath moves with the
    // old dir on a tick and sees the new one from the following tick on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            move_tick <= 1'b0;
            dir       <= DIR_RIGHT;
            pend_vld  <= 1'b0;
            pend_dir  <= DIR_UP;
            key_any   <= 1'b0;
        end else begin
            key_any   <= press_any;
            move_tick <= 1'b0;
            case (status)
                ST_RESTART: begin
                    dir      <= DIR_RIGHT;
                    pend_vld <= 1'b0;
                    tick_cnt <= '0;
                end
                ST_START: begin
                    pend_vld <= 1'b0;
                    tick_cnt <= '0;
                    if (press_any) begin
                        dir <= press_dir;
                    end
                end
                ST_PLAY: begin
                    // >= keeps the counter bounded if the period shrinks mid-interval
                    if (tick_cnt >= period - 32'd1) begin
                        move_tick <= 1'b1;
                        tick_cnt  <= '0;
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                    if (move_tick) begin
                        if (pend_vld && (pend_dir != opposite(dir))) begin
                            dir <= pend_dir;
                        end
                        pend_vld <= 1'b0;
                    end
                    // a press on the tick cycle survives the clear for the next tick
                    if (press_any) begin
                        pend_vld <= 1'b1;
                        pend_dir <= press_dir;
                    end
                end
                default: begin
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: a level-decode vector table plus scripted
// sequences; expected move_tick / key_any cycles go into scoreboard queues and
// are matched whenever the DUT raises the strobe.
module tb_snake_move_scheduler;

    localparam int DEB   = 4;
    localparam int P_E   = 20;
    localparam int P_M   = 10;
    localparam int P_H   = 5;
    localparam int STEP  = 2;
    localparam int P_MIN = 3;

    localparam logic [1:0] GS_START   = 2'b00;
    localparam logic [1:0] GS_RESTART = 2'b01;
    localparam logic [1:0] GS_PLAY    = 2'b10;
    localparam logic [1:0] GS_DIE     = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key0_right, key1_left, key2_down, key3_up;
    logic        sw0, sw1, sw2;
    logic [1:0]  game_status;
    logic [11:0] bcd_data;
    logic        move_tick;
    logic [1:0]  dir;
    logic [1:0]  level;
    logic        key_any;

    always #5 clk = ~clk;

    snake_move_scheduler #(
        .DEB_CYCLES  (DEB),
        .PERIOD_EASY (P_E),
        .PERIOD_MID  (P_M),
        .PERIOD_HARD (P_H),
        .SPEEDUP_STEP(STEP),
        .PERIOD_MIN  (P_MIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key0_right (key0_right),
        .key1_left  (key1_left),
        .key2_down  (key2_down),
        .key3_up    (key3_up),
        .sw0        (sw0),
        .sw1        (sw1),
        .sw2        (sw2),
        .game_status(game_status),
        .bcd_data   (bcd_data),
        .move_tick  (move_tick),
        .dir        (dir),
        .level      (level),
        .key_any    (key_any)
    );

    typedef struct {
        logic [1:0] gs;
        logic [2:0] sw;        // {sw2, sw1, sw0}
        logic [1:0] exp_level;
    } vec_t;

    vec_t vecs [10];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   tick_q [$];
    int   key_q  [$];

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and match strobes against the queues.
    task automatic step();
        int e;
        @(negedge clk);
        cyc++;
        if (move_tick) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: move_tick at cycle %0d, none expected", cyc);
            end else begin
                e = tick_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL tick_time: move_tick at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end else if (tick_q.size() != 0 && tick_q[0] <= cyc) begin
            checks++;
            errors++;
            e = tick_q.pop_front();
            $display("FAIL tick_missing: no move_tick at cycle %0d, expected at %0d", cyc, e);
        end
        if (key_any) begin
            checks++;
            if (key_q.size() == 0) begin
                errors++;
                $display("FAIL key_unexpected: key_any at cycle %0d, none expected", cyc);
            end else begin
                e = key_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL key_time: key_any at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end else if (key_q.size() != 0 && key_q[0] <= cyc) begin
            checks++;
            errors++;
            e = key_q.pop_front();
            $display("FAIL key_missing: no key_any at cycle %0d, expected at %0d", cyc, e);
        end
    endtask

    task automatic drained(input string name);
        checks++;
        if (tick_q.size() != 0 || key_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d ticks and %0d key events still outstanding, expected 0 and 0",
                     name, tick_q.size(), key_q.size());
        end
        tick_q.delete();
        key_q.delete();
    endtask

    task automatic run_speed(input logic [3:0] tens, input int interval, input string name);
        int p;
        game_status = GS_RESTART;
        bcd_data    = {4'd0, tens, 4'd0};
        step();
        game_status = GS_PLAY;
        p = cyc;
        for (int k = 1; k <= 3; k++) tick_q.push_back(p + k * interval);
        repeat (3 * interval + 2) step();
        game_status = GS_RESTART;
        step();
        drained(name);
    endtask

    initial begin
        int p0, d0, s0, p1;
        int i_fast, i_floor;

        vecs[0] = '{GS_RESTART, 3'b111, 2'b01};
        vecs[1] = '{GS_RESTART, 3'b011, 2'b11};
        vecs[2] = '{GS_RESTART, 3'b111, 2'b11};
        vecs[3] = '{GS_RESTART, 3'b101, 2'b10};
        vecs[4] = '{GS_RESTART, 3'b110, 2'b01};
        vecs[5] = '{GS_RESTART, 3'b000, 2'b11};
        vecs[6] = '{GS_RESTART, 3'b100, 2'b10};
        vecs[7] = '{GS_DIE,     3'b011, 2'b10};
        vecs[8] = '{GS_START,   3'b110, 2'b10};
        vecs[9] = '{GS_RESTART, 3'b110, 2'b01};

`ifdef SNAKE_SPEEDUP_EN
        i_fast  = 12;
        i_floor = 3;
`else
        i_fast  = 20;
        i_floor = 20;
`endif

        rst_n       = 1'b0;
        key0_right  = 1'b1;
        key1_left   = 1'b1;
        key2_down   = 1'b1;
        key3_up     = 1'b1;
        {sw2, sw1, sw0} = 3'b111;
        game_status = GS_RESTART;
        bcd_data    = '0;
        repeat (3) step();
        check1("reset_move_tick", move_tick, 1'b0);
        check2("reset_dir", dir, 2'b11);
        check2("reset_level", level, 2'b01);
        check1("reset_key_any", key_any, 1'b0);
        rst_n = 1'b1;
        step();

        // level decode and freeze
        for (int i = 0; i < 10; i++) begin
            game_status     = vecs[i].gs;
            {sw2, sw1, sw0} = vecs[i].sw;
            step();
            check2($sformatf("level_vec%0d", i), level, vecs[i].exp_level);
        end
        check2("dir_after_table", dir, 2'b11);

        // medium level: ticks every 10 cycles
        game_status     = GS_RESTART;
        {sw2, sw1, sw0} = 3'b101;
        step();
        check2("level_mid", level, 2'b10);
        game_status = GS_PLAY;
        p0 = cyc;
        for (int k = 1; k <= 3; k++) tick_q.push_back(p0 + k * P_M);
        repeat (35) step();
        game_status = GS_RESTART;
        repeat (3) step();
        drained("ticks_mid");

        // bouncing up key, then held low: one key_any, 7 cycles after stable low
        for (int i = 0; i < 12; i++) begin
            key3_up = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key3_up = 1'b0;
        key_q.push_back(cyc + 7);
        repeat (10) step();
        key3_up = 1'b1;
        repeat (10) step();
        drained("bounce");
        check2("restart_dir_after_key", dir, 2'b11);

        // easy level direction handling
        {sw2, sw1, sw0} = 3'b110;
        step();
        check2("level_easy", level, 2'b01);
        game_status = GS_PLAY;
        key1_left   = 1'b0;
        p0 = cyc;
        for (int k = 1; k <= 4; k++) tick_q.push_back(p0 + k * P_E);
        key_q.push_back(p0 + 7);
        repeat (6) step();
        key1_left = 1'b1;
        repeat (16) step();                 // p0+22
        check2("reverse_rejected", dir, 2'b11);
        key3_up = 1'b0;
        key_q.push_back(p0 + 29);
        repeat (2) step();                  // p0+24
        key2_down = 1'b0;
        key_q.push_back(p0 + 31);
        repeat (4) step();                  // p0+28
        key3_up = 1'b1;
        repeat (2) step();                  // p0+30
        key2_down = 1'b1;
        repeat (9) step();                  // p0+39
        check2("dir_before_tick", dir, 2'b11);
        repeat (2) step();                  // p0+41
        check2("latest_press_wins", dir, 2'b01);
        repeat (13) step();                 // p0+54
        key1_left = 1'b0;
        key_q.push_back(p0 + 61);
        repeat (6) step();                  // p0+60, press event lands on tick cycle
        key1_left = 1'b1;
        step();                             // p0+61
        check2("coincident_hold", dir, 2'b01);
        repeat (20) step();                 // p0+81
        check2("coincident_next", dir, 2'b10);
        repeat (4) step();                  // p0+85

        // DIE freezes everything except key_any
        game_status = GS_DIE;
        d0 = cyc;
        repeat (2) step();
        key3_up = 1'b0;
        key_q.push_back(d0 + 9);
        repeat (6) step();
        key3_up = 1'b1;
        repeat (32) step();
        check2("die_frozen", dir, 2'b10);
        drained("die");
        game_status = GS_RESTART;
        step();
        check2("restart_dir", dir, 2'b11);

        // START loads dir directly, even the reverse of right
        game_status = GS_START;
        step();
        key1_left = 1'b0;
        s0 = cyc;
        key_q.push_back(s0 + 7);
        repeat (6) step();
        key1_left = 1'b1;
        step();
        check2("start_load", dir, 2'b10);
        game_status = GS_PLAY;
        p1 = cyc;
        tick_q.push_back(p1 + P_E);
        repeat (22) step();
        game_status = GS_DIE;
        step();
        drained("start_to_play");
        check2("dir_kept_play", dir, 2'b10);

        // score-dependent interval
        run_speed(4'd4, i_fast, "speed_tens4");
        run_speed(4'd9, i_floor, "speed_tens9");

        // asynchronous reset mid-interval
        bcd_data        = '0;
        {sw2, sw1, sw0} = 3'b011;
        step();
        check2("level_hard", level, 2'b11);
        game_status = GS_START;
        step();
        key2_down = 1'b0;
        key_q.push_back(cyc + 7);
        repeat (6) step();
        key2_down = 1'b1;
        step();
        check2("start_down", dir, 2'b01);
        game_status = GS_PLAY;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check2("async_dir", dir, 2'b11);
        check2("async_level", level, 2'b01);
        check1("async_tick", move_tick, 1'b0);
        game_status     = GS_RESTART;
        {sw2, sw1, sw0} = 3'b111;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        check2("post_reset_level_hold", level, 2'b01);
        drained("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
